// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Width of the per-bit tick counter at the default 16x oversampling rate.
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int TICK_W             = $clog2(DEFAULT_OVERSAMPLE);

  // Divisor from clk to the oversampling tick, rounded to the nearest integer.
  function automatic int calc_div(input longint clk_freq, input longint baud, input longint os);
    longint den;
    den = baud * os;
    return int'((clk_freq + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks.
// The synchronous clear lets a receiver realign the tick phase to a start edge.
module uart_baud_tick #(
  parameter int DIV = 163
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Count 0..DIV-1 while enabled, wrapping on the last value; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: 2-flop synchronizer, oversampled mid-bit sampling with
// start-glitch rejection, stop-bit check, break hold-off and a valid/accept
// holding register with framing-error and overrun pulses.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 19200,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rxByte,
  output logic                  rxValid,
  input  logic                  rxAccept,
  output logic                  frameError,
  output logic                  overrun,
  output logic                  busy
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);

  rx_state_t             state;
  rx_state_t             next_state;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  tick;
  logic [CNT_W-1:0]      tick_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  half_done;
  logic                  full_done;
  logic                  stop_ok;
  logic                  stop_bad;

  // Bring the asynchronous line into the clk domain; idle level is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Divider is held cleared while idle so tick phase aligns to the start edge.
  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .enable(1'b1),
    .tick  (tick)
  );

  assign half_done = tick && (tick_cnt == HALF_LAST);
  assign full_done = tick && (tick_cnt == FULL_LAST);
  assign stop_ok   = (state == STOP) && full_done && rx_s;
  assign stop_bad  = (state == STOP) && full_done && !rx_s;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame sequencing: start check at half bit, then one sample per full bit.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (half_done) next_state = rx_s ? IDLE : DATA;
      DATA:    if (full_done && (bit_idx == LAST_BIT)) next_state = STOP;
      STOP:    if (full_done) next_state = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Tick counting within a bit and LSB-first capture of data bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        START: begin
          if (half_done) begin
            tick_cnt <= '0;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (full_done) begin
            tick_cnt           <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (full_done) begin
            tick_cnt <= '0;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          tick_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

  // Holding register: load on a good stop bit unless still full; an accept in
  // the completion cycle frees the slot in time for the new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxByte     <= '0;
      rxValid    <= 1'b0;
      frameError <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frameError <= stop_bad;
      overrun    <= 1'b0;
      if (stop_ok) begin
        if (!rxValid || rxAccept) begin
          rxByte  <= shift_reg;
          rxValid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rxValid && rxAccept) begin
        rxValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer running at a fast line rate
// (CLK_FREQ 50 MHz, BAUD 250000: divisor rounds 12.5 up to 13, 208 clks/bit).
module tb_uart_rx_deframer;
  import uart_pkg::*;

  localparam int BIT     = 208;
  localparam int LATENCY = 1979;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxAccept;
  logic       frameError;
  logic       overrun;
  logic       busy;

  int num_compared   = 0;
  int num_mismatched = 0;

  int cyc          = 0;
  int fe_cnt       = 0;
  int ov_cnt       = 0;
  int rise_cnt     = 0;
  int rise_cyc     = 0;
  int valid_cycles = 0;
  logic prev_valid = 1'b0;
  int start_cyc    = 0;

  int base_fe, base_ov, base_rise, base_vc, t0, k;

  uart_rx_deframer #(
    .DATA_WIDTH(8),
    .BAUD_RATE (250000),
    .CLK_FREQ  (50_000_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxByte    (rxByte),
    .rxValid   (rxValid),
    .rxAccept  (rxAccept),
    .frameError(frameError),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor sampling outputs on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frameError) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
    if (rxValid && !prev_valid) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    if (rxValid) valid_cycles = valid_cycles + 1;
    prev_valid = rxValid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared = num_compared + 1;
    if (observed !== expected) begin
      num_mismatched = num_mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Drive one frame: start bit, 8 data bits LSB first, then the given stop level.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    @(negedge clk);
    #1;
    start_cyc = cyc;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT) @(negedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    #1;
  endtask

  task automatic snapshot();
    base_fe   = fe_cnt;
    base_ov   = ov_cnt;
    base_rise = rise_cnt;
    base_vc   = valid_cycles;
  endtask

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    rxAccept = 1'b0;

    checkOutput("div_default", calc_div(50_000_000, 19200, 16), 163);
    checkOutput("div_bench", calc_div(50_000_000, 250000, 16), 13);

    // Test 1: reset values, mid-frame reset abort.
    $display("[TB] test 1: reset");
    waitCycles(3);
    checkOutput("rst_rxByte", rxByte, 8'h00);
    checkOutput("rst_rxValid", rxValid, 0);
    checkOutput("rst_frameError", frameError, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    rx  = 1'b0;
    waitCycles(1000);
    checkOutput("t1_busy_midframe", busy, 1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("t1_busy_in_rst", busy, 0);
    checkOutput("t1_valid_in_rst", rxValid, 0);
    waitCycles(2);
    rst = 1'b0;
    rx  = 1'b1;
    snapshot();
    waitCycles(3);
    checkOutput("t1_busy_after", busy, 0);
    checkOutput("t1_valid_after", rxValid, 0);
    waitCycles(2200);
    checkOutput("t1_no_valid", rise_cnt - base_rise, 0);
    checkOutput("t1_no_fe", fe_cnt - base_fe, 0);

    // Test 2: clean frame with consumer always ready.
    $display("[TB] test 2: 0xA5");
    rxAccept = 1'b1;
    snapshot();
    applyStimulus(8'hA5, 1'b1);
    waitCycles(BIT);
    checkOutput("t2_rise", rise_cnt - base_rise, 1);
    checkOutput("t2_valid_cycles", valid_cycles - base_vc, 1);
    checkOutput("t2_latency", rise_cyc - start_cyc, LATENCY);
    checkOutput("t2_rxByte", rxByte, 8'hA5);
    checkOutput("t2_rxValid", rxValid, 0);
    checkOutput("t2_fe", fe_cnt - base_fe, 0);
    checkOutput("t2_ov", ov_cnt - base_ov, 0);

    // Test 3: short low glitch shorter than half a bit.
    $display("[TB] test 3: glitch");
    snapshot();
    @(negedge clk);
    #1;
    t0 = cyc;
    rx = 1'b0;
    waitCycles(52);
    rx = 1'b1;
    checkOutput("t3_busy_high", busy, 1);
    for (k = 0; k < 400 && busy; k++) waitCycles(1);
    checkOutput("t3_busy_timeout", busy, 0);
    checkOutput("t3_busy_fall", cyc - t0, 107);
    waitCycles(BIT);
    checkOutput("t3_no_valid", rise_cnt - base_rise, 0);
    checkOutput("t3_no_fe", fe_cnt - base_fe, 0);

    // Test 4: framing error followed by a held-low line, then a good frame.
    $display("[TB] test 4: framing error and break");
    snapshot();
    applyStimulus(8'h3C, 1'b0);
    waitCycles(3 * BIT);
    checkOutput("t4_busy_break", busy, 1);
    checkOutput("t4_fe", fe_cnt - base_fe, 1);
    checkOutput("t4_no_valid", rise_cnt - base_rise, 0);
    rx = 1'b1;
    waitCycles(BIT);
    checkOutput("t4_busy_idle", busy, 0);
    applyStimulus(8'h81, 1'b1);
    waitCycles(BIT);
    checkOutput("t4_rise", rise_cnt - base_rise, 1);
    checkOutput("t4_rxByte", rxByte, 8'h81);
    checkOutput("t4_fe_total", fe_cnt - base_fe, 1);

    // Test 5: two frames with no consumer; second is dropped.
    $display("[TB] test 5: overrun");
    rxAccept = 1'b0;
    snapshot();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    waitCycles(BIT);
    checkOutput("t5_rxByte", rxByte, 8'h11);
    checkOutput("t5_rxValid", rxValid, 1);
    checkOutput("t5_ov", ov_cnt - base_ov, 1);
    checkOutput("t5_rise", rise_cnt - base_rise, 1);
    rxAccept = 1'b1;
    waitCycles(1);
    rxAccept = 1'b0;
    checkOutput("t5_cleared", rxValid, 0);

    // Test 6: accept exactly in the completion cycle of the next byte.
    $display("[TB] test 6: accept on completion");
    snapshot();
    applyStimulus(8'h11, 1'b1);
    waitCycles(BIT);
    checkOutput("t6_first_valid", rxValid, 1);
    checkOutput("t6_first_byte", rxByte, 8'h11);
    fork
      applyStimulus(8'h22, 1'b1);
      begin
        @(negedge clk);
        repeat (LATENCY - 1) @(negedge clk);
        #1;
        rxAccept = 1'b1;
        @(negedge clk);
        #1;
        rxAccept = 1'b0;
      end
    join
    waitCycles(BIT);
    checkOutput("t6_rxByte", rxByte, 8'h22);
    checkOutput("t6_rxValid", rxValid, 1);
    checkOutput("t6_ov", ov_cnt - base_ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
